// File: rtl/theremin_period_sample_fifo.sv
// theremin_period_sample_fifo
// Decimating sampler plus first-word-fall-through FIFO for the theremin
// sensor path. Every DECIMATION+1 enabled cycles the filtered pitch and
// volume period words are captured as one pair and queued. The queue drains
// through a valid/ready stream, and dropped samples are counted.
//
// Build option: define THEREMIN_SAMPLE_SEQ_EN to build the 8-bit sequence
// counter and per-entry tag storage. Without it, OUT_SEQ is tied to 0 and
// FIFO entries hold only the two period words.
module theremin_period_sample_fifo #(
  parameter int DATA_BITS  = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int DECIM_BITS = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_BITS-1:0]  PITCH_PERIOD,
  input  logic [DATA_BITS-1:0]  VOLUME_PERIOD,
  input  logic                  ENABLE,
  input  logic [DECIM_BITS-1:0] DECIMATION,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_BITS-1:0]  OUT_PITCH,
  output logic [DATA_BITS-1:0]  OUT_VOLUME,
  output logic [7:0]            OUT_SEQ,
  output logic [DEPTH_LOG2:0]   FIFO_LEVEL,
  output logic [15:0]           OVERFLOW_COUNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
`ifdef THEREMIN_SAMPLE_SEQ_EN
  localparam int SEQ_W = 8;
`else
  localparam int SEQ_W = 0;
`endif
  localparam int ENTRY_W = 2 * DATA_BITS + SEQ_W;

  // Output handshake: OUT_VALID is high whenever the FIFO holds an entry and
  // the head words are then held stable until the cycle where OUT_VALID and
  // OUT_READY are both high; that cycle is a pop and the next head (or
  // OUT_VALID=0) appears after the following clock edge. OUT_READY may be
  // driven independently of OUT_VALID.

  // ---------------------------------------------------------------------
  // Decimation counter
  // ---------------------------------------------------------------------
  logic [DECIM_BITS-1:0] decim_cnt;
  logic                  tick;

  // A tick fires on an enabled cycle whose counter has reached zero.
  always_comb begin
    tick = ENABLE && (decim_cnt == '0);
  end

  // Count down while enabled, reload on a tick; park at the reload value when
  // disabled so a new DECIMATION only lands at a reload boundary.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      decim_cnt <= '0;
    end else if (!ENABLE) begin
      decim_cnt <= DECIMATION;
    end else if (tick) begin
      decim_cnt <= DECIMATION;
    end else begin
      decim_cnt <= decim_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and flow control
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // Full/empty from the extra pointer MSB; a full FIFO still accepts a tick
  // when the head is popped in the same cycle.
  always_comb begin
    wr_addr    = wr_ptr[DEPTH_LOG2-1:0];
    rd_addr    = rd_ptr[DEPTH_LOG2-1:0];
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    pop        = !fifo_empty && OUT_READY;
    push       = tick && (!fifo_full || pop);
    drop       = tick && !push;
    wr_ptr_nxt = wr_ptr + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_nxt = rd_ptr + {{(PTR_W-1){1'b0}}, pop};
  end

  // Pointer and occupancy registers; the level is the modular pointer
  // difference, so a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      FIFO_LEVEL <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // Saturating count of ticks that found the FIFO full with no pop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERFLOW_COUNT <= '0;
    end else if (drop && (OVERFLOW_COUNT != 16'hFFFF)) begin
      OVERFLOW_COUNT <= OVERFLOW_COUNT + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Entry formation and optional sequence tag
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

`ifdef THEREMIN_SAMPLE_SEQ_EN
  logic [7:0] seq_cnt;

  // Tag advances on every tick, dropped or not, so gaps are visible
  // downstream; it wraps naturally at 8 bits.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seq_cnt <= '0;
    end else if (tick) begin
      seq_cnt <= seq_cnt + 8'd1;
    end
  end

  // Entry layout: {tag, pitch, volume}.
  always_comb begin
    wr_entry = {seq_cnt, PITCH_PERIOD, VOLUME_PERIOD};
  end
`else
  // Entry layout: {pitch, volume}.
  always_comb begin
    wr_entry = {PITCH_PERIOD, VOLUME_PERIOD};
  end
`endif

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];

  // Sample storage; contents are only observable behind a valid pointer
  // range, so the array carries no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------
  // Head presentation (first-word-fall-through)
  // ---------------------------------------------------------------------
  // Head is read straight from the array and forced to zero while empty,
  // which also gives zero outputs out of reset.
  always_comb begin
    head_entry = mem[rd_addr];
    OUT_VALID  = !fifo_empty;
    OUT_PITCH  = '0;
    OUT_VOLUME = '0;
    OUT_SEQ    = '0;
    if (!fifo_empty) begin
      OUT_PITCH  = head_entry[2*DATA_BITS-1:DATA_BITS];
      OUT_VOLUME = head_entry[DATA_BITS-1:0];
`ifdef THEREMIN_SAMPLE_SEQ_EN
      OUT_SEQ    = head_entry[ENTRY_W-1 -: 8];
`endif
    end
  end

endmodule

// File: doc/theremin_period_sample_fifo.md
# theremin_period_sample_fifo

Decimating sampler and output buffer for the theremin sensor path. It sits directly downstream of the oversampling period-measure / IIR filter stage and runs in that stage's parallel clock domain. It periodically captures the filtered pitch and volume period words as one pair and queues them in a small first-word-fall-through FIFO. The FIFO drains through a valid/ready stream towards the processor-side interface, with overflow accounting.

## Interface
Parameters:
- DATA_BITS, 32, width of each filtered period word.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 entries.
- DECIM_BITS, 16, width of the decimation reload value.

Ports:
- CLK  in  1  single clock, the filter stage's parallel clock (150 MHz).
- RESET_N  in  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- PITCH_PERIOD  in  DATA_BITS  filtered pitch period, valid every cycle.
- VOLUME_PERIOD  in  DATA_BITS  filtered volume period, valid every cycle.
- ENABLE  in  1  sampling enable.
- DECIMATION  in  DECIM_BITS  sample interval minus one, in CLK cycles.
- OUT_VALID  out  1  FIFO head is valid.
- OUT_READY  in  1  consumer accepts the head.
- OUT_PITCH  out  DATA_BITS  head pitch word.
- OUT_VOLUME  out  DATA_BITS  head volume word.
- OUT_SEQ  out  8  head sequence tag.
- FIFO_LEVEL  out  DEPTH_LOG2+1  current occupancy.
- OVERFLOW_COUNT  out  16  dropped-sample count, saturating.

## Operation
- **Decimation counter (DECIM_BITS):**
  - While ENABLE=0, the counter is held at DECIMATION and no ticks occur.
  - While ENABLE=1, it decrements each cycle.
  - At 0 it issues a sample tick and reloads DECIMATION.
  - Result: one tick every DECIMATION+1 cycles; DECIMATION=0 gives a tick every cycle.
  - A DECIMATION change takes effect at the next reload, not mid-count.
- **Capture:** on a tick, the entry {seq, PITCH_PERIOD, VOLUME_PERIOD} is sampled from that same cycle's inputs.
- **Sequence counter (8 bit):**
  - Increments on every tick, including dropped ticks, so the consumer detects gaps.
  - Wraps 255 to 0.
- **Push:** accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- **Drop:** otherwise the sample is dropped and OVERFLOW_COUNT increments, saturating at 0xFFFF. It is cleared only by reset.
- **Pop:** occurs when OUT_VALID=1 and OUT_READY=1.
- **Output stream:**
  - OUT_VALID = FIFO not empty.
  - The head outputs are stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_PITCH, OUT_VOLUME and OUT_SEQ are don't-care while OUT_VALID=0.
- **FIFO structure:** binary read/write pointers of DEPTH_LOG2+1 bits; full = MSBs differ and the remaining bits are equal.
- **FIFO_LEVEL:** equals write pointer minus read pointer, modulo 2^(DEPTH_LOG2+1).
- **Push and pop in one cycle:** FIFO_LEVEL is unchanged; both pointers advance.
- **ENABLE deassertion:** stops ticks only. The FIFO continues to drain; queued entries are not flushed.

## Timing
- **Reset values:**
  - OUT_VALID=0, FIFO_LEVEL=0, OVERFLOW_COUNT=0.
  - OUT_PITCH, OUT_VOLUME and OUT_SEQ = 0.
  - Sequence counter = 0, pointers = 0.
  - Decimation counter = 0, so the first tick occurs on the first enabled cycle after reset; subsequent ticks follow every DECIMATION+1 cycles.
- **Latency:** a tick at cycle N with the FIFO empty gives OUT_VALID=1 at N+1, presenting the cycle-N input values.
- **Pop response:** a pop at cycle N updates the head (or clears OUT_VALID) at N+1.
- **Throughput:** one push and one pop per cycle are sustainable.
- **FIFO_LEVEL and OVERFLOW_COUNT:** both are registered and update one cycle after the causing event.
- **Reset mid-operation:** asserting RESET_N low clears all state immediately (asynchronous). Release is synchronous to CLK, and the block resumes as after power-up.

## Configuration
- **THEREMIN_SAMPLE_SEQ_EN defined:**
  - The 8-bit sequence tag is stored per entry.
  - OUT_SEQ carries the tag as described above.
- **THEREMIN_SAMPLE_SEQ_EN undefined:**
  - Neither the sequence counter nor the tag storage is built; FIFO entries are 2*DATA_BITS wide.
  - OUT_SEQ is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Basic decimation:** DECIMATION=9, ENABLE=1, OUT_READY=1, PITCH_PERIOD = cycle count.
  - Ticks occur every 10 cycles.
  - OUT_PITCH values differ by 10.
  - OUT_SEQ increments 0,1,2,...
  - FIFO_LEVEL never exceeds 1.
- **Overflow:** DEPTH_LOG2=4, DECIMATION=0, OUT_READY=0 for 20 cycles.
  - FIFO_LEVEL reaches 16.
  - OVERFLOW_COUNT = 4.
  - Draining shows OUT_SEQ 0..15.
  - The next accepted entry after resuming has a tag gap (skips 16..19).
- **Full with simultaneous pop:** FIFO full, tick and pop in the same cycle.
  - FIFO_LEVEL stays 16.
  - OVERFLOW_COUNT is unchanged.
  - The new entry appears last.
- **Backpressure stability:** OUT_READY toggling pseudo-randomly with DECIMATION=2.
  - Output words are held stable while stalled.
  - There is no loss or duplication against the scoreboard.
  - The sequence tag wraps 255 to 0 correctly.
- **Enable gating and mid-run reset:**
  - ENABLE=0 for 50 cycles produces no new entries, and the queued entries drain.
  - RESET_N low mid-burst immediately gives OUT_VALID=0, FIFO_LEVEL=0 and OVERFLOW_COUNT=0.
  - After release, the first tag is 0.
- **Macro undefined build:** repeat the basic decimation test; OUT_SEQ is constant 0 and the data matches.
